// File: rtl/prio_arb_pkg.sv
// rtl/prio_arb_pkg.sv - shared types and helpers for the prio_arb priority arbiter
package prio_arb_pkg;

   // Widest request vector the arbiter supports; the helper works on this width.
   localparam int MAX_N = 64;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Highest set bit index of vec; returns 0 when vec is all-zero (callers
   // must qualify the result with |vec).
   function automatic logic [5:0] prio_idx(input logic [MAX_N-1:0] vec);
      logic [5:0] r;
      r = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (vec[i]) r = 6'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_arb_pick.sv
// rtl/prio_arb_pick.sv - combinational N-wide winner search, fixed or rotating priority
module prio_arb_pick
   import prio_arb_pkg::*;
#(
   parameter int N  = 8,
   parameter int W  = $clog2(N),
   parameter bit RR = 1'b0
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         found,
   output logic [W-1:0] idx
);

   int               base;
   int               j;
   int               sum;
   logic [MAX_N-1:0] rot;
   logic [5:0]       k;

   // Rotate req so the lowest-priority line lands in bit 0, take the highest
   // set bit, then rotate the index back. Rotating mode puts ptr itself
   // lowest (search starts at ptr-1); fixed mode is driven with ptr = N-1 and
   // starts the rotation at ptr+1 = 0, which is plain MSB-first priority.
   always_comb begin
      base = int'(ptr);
      if (!RR) base = base + 1;
      if (base >= N) base = base - N;
      rot = '0;
      j   = 0;
      for (int i = 0; i < N; i++) begin
         j = base + i;
         if (j >= N) j = j - N;
         rot[i] = req[j];
      end
      k   = prio_idx(rot);
      sum = base + int'(k);
      if (sum >= N) sum = sum - N;
      idx   = W'(sum);
      found = |req;
   end

endmodule

// File: rtl/prio_arb.sv
// rtl/prio_arb.sv - registered N-way priority arbiter with sticky grant; PRIO_ARB_ROUND_ROBIN_EN selects rotating priority
module prio_arb
   import prio_arb_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic         gnt_vld,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_oh,
   output logic         none
);

   arb_state_e   state, state_nxt;
   logic [W-1:0] idx_nxt;
   logic [N-1:0] oh_nxt;
   logic         none_nxt;
   logic         latch;
   logic         pick_found;
   logic [W-1:0] pick_idx;
   logic [W-1:0] ptr;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;

   // Last granted index; its line becomes lowest priority for the next search.
   always_ff @(posedge clk) begin
      if (!rst_n)     ptr <= W'(N-1);
      else if (latch) ptr <= pick_idx;
   end
`else
   localparam bit RR = 1'b0;

   assign ptr = W'(N-1);
`endif

   prio_arb_pick #(.N(N), .W(W), .RR(RR)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign gnt_vld = (state == ARB_GRANT);

   // Next-state and grant-register values; a grant is frozen until acked,
   // and an ack with pending requests re-arbitrates without a bubble.
   always_comb begin
      state_nxt = state;
      idx_nxt   = gnt_idx;
      oh_nxt    = gnt_oh;
      none_nxt  = none;
      latch     = 1'b0;
      case (state)
         ARB_IDLE: begin
            none_nxt = ~|req;
            if (en && pick_found) latch = 1'b1;
         end
         ARB_GRANT: begin
            if (ack) begin
               none_nxt = ~|req;
               if (en && pick_found) begin
                  latch = 1'b1;
               end else begin
                  state_nxt = ARB_IDLE;
                  oh_nxt    = '0;
               end
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
      if (latch) begin
         state_nxt = ARB_GRANT;
         idx_nxt   = pick_idx;
         oh_nxt    = {{(N-1){1'b0}}, 1'b1} << pick_idx;
      end
   end

   // State and grant registers; reset aborts any grant in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ARB_IDLE;
         gnt_idx <= '0;
         gnt_oh  <= '0;
         none    <= 1'b1;
      end else begin
         state   <= state_nxt;
         gnt_idx <= idx_nxt;
         gnt_oh  <= oh_nxt;
         none    <= none_nxt;
      end
   end

endmodule
